// File: rtl/median_pkg.sv
// Shared definitions for the 7x7 median path.
//   WIN     : window size (rows/columns of the median window)
//   HALF    : distance from the window centre to its edge
//   pixel_t : one 8-bit grey pixel
//   state_t : line-buffer controller state
package median_pkg;

  localparam int WIN  = 7;
  localparam int HALF = 3;

  typedef logic [7:0] pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    FLUSH
  } state_t;

endpackage

// File: rtl/median_line_fifo.sv
// One line of pixel storage for the median line buffer.
// A DEPTH-entry shift line: every enabled cycle the head entry leaves and
// din enters at the tail, so head is always the pixel pushed DEPTH enables
// earlier (the same column of the previous row).
//   clk  : rising-edge clock
//   en   : push din / pop head in the same cycle
//   din  : pixel entering the line
//   head : pixel that will leave on the next enable
// Contents are deliberately not reset; the controller never emits a tap
// before the line has been refilled with the current frame.
module median_line_fifo
  import median_pkg::*;
#(
  parameter int DEPTH = 9
) (
  input  logic   clk,
  input  logic   en,
  input  pixel_t din,
  output pixel_t head
);

  pixel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      mem[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign head = mem[DEPTH-1];

endmodule

// File: rtl/median_line_buffer_7row.sv
// Producer side of the 7x7 median path: turns a raster pixel stream into
// one 7-pixel vertical column per accepted beat.
//   clk            : rising-edge clock
//   rst            : asynchronous, active-low reset
//   d_i / done_i   : input pixel and its valid
//   ready_o        : pixel accepted when done_i & ready_o
//   d0_o..d6_o     : registered column taps, d0_o oldest row, d6_o newest
//   done_o         : taps valid this cycle
//   frame_done_o   : pulse with the last done_o of a frame
//   state_o        : controller state, for observation
// Handshake: a beat transfers on a rising edge where done_i and ready_o are
// both high; ready_o only drops during FLUSH and never depends on done_i.
// Build option MEDIAN_LINE_BUF_ZERO_PAD_EN: zero-pad top and bottom so
// that every input row yields an output row (adds the FLUSH phase).
module median_line_buffer_7row
  import median_pkg::*;
#(
  parameter int ROWS = 9,
  parameter int COLS = 9
) (
  input  logic   clk,
  input  logic   rst,
  input  pixel_t d_i,
  input  logic   done_i,
  output logic   ready_o,
  output pixel_t d0_o,
  output pixel_t d1_o,
  output pixel_t d2_o,
  output pixel_t d3_o,
  output pixel_t d4_o,
  output pixel_t d5_o,
  output pixel_t d6_o,
  output logic   done_o,
  output logic   frame_done_o,
  output state_t state_o
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  // row_cnt also walks the three virtual rows below the frame in FLUSH
  localparam int RW = $clog2(ROWS + HALF + 1);
`ifdef MEDIAN_LINE_BUF_ZERO_PAD_EN
  localparam int ROW_START = HALF;
`else
  localparam int ROW_START = WIN - 1;
`endif
  localparam logic [CW-1:0] COL_LAST  = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
  localparam logic [RW-1:0] FILL_LAST = RW'(ROW_START - 1);
`ifdef MEDIAN_LINE_BUF_ZERO_PAD_EN
  localparam logic [RW-1:0] FLUSH_LAST = RW'(ROWS + HALF - 1);
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic          accept, shift_en, emit, frame_last, col_last;
  pixel_t        push_px;
  pixel_t        head  [WIN-1];
  pixel_t        tap   [WIN];
  pixel_t        tap_q [WIN];

  assign ready_o  = (state != FLUSH);
  assign accept   = done_i & ready_o;
  assign col_last = (col_cnt == COL_LAST);
  assign state_o  = state;

`ifdef MEDIAN_LINE_BUF_ZERO_PAD_EN
  // FLUSH shifts zeros in as the rows below the frame
  assign shift_en = accept | (state == FLUSH);
  assign push_px  = (state == FLUSH) ? '0 : d_i;
`else
  assign shift_en = accept;
  assign push_px  = d_i;
`endif

  // Cascade: line k holds row r-6+k at the current column; line 5 is fed
  // by the incoming pixel, each lower line by the head of the one above.
  for (genvar k = 0; k < WIN - 1; k++) begin : g_line
    if (k == WIN - 2) begin : g_top
      median_line_fifo #(.DEPTH(COLS)) u_fifo (
        .clk  (clk),
        .en   (shift_en),
        .din  (push_px),
        .head (head[k])
      );
    end else begin : g_mid
      median_line_fifo #(.DEPTH(COLS)) u_fifo (
        .clk  (clk),
        .en   (shift_en),
        .din  (head[k+1]),
        .head (head[k])
      );
    end
  end

  always_comb begin
    for (int k = 0; k < WIN - 1; k++) begin
      tap[k] = head[k];
`ifdef MEDIAN_LINE_BUF_ZERO_PAD_EN
      // rows above the frame top read as zero
      if (int'(row_cnt) + k < WIN - 1) tap[k] = '0;
`endif
    end
    tap[WIN-1] = push_px;
  end

  always_comb begin
    state_nxt  = state;
    emit       = 1'b0;
    frame_last = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = FILL;
      end
      FILL: begin
        if (accept && col_last && row_cnt == FILL_LAST) state_nxt = RUN;
      end
      RUN: begin
        if (accept) begin
          emit = 1'b1;
          if (col_last && row_cnt == ROW_LAST) begin
`ifdef MEDIAN_LINE_BUF_ZERO_PAD_EN
            state_nxt = FLUSH;
`else
            state_nxt  = IDLE;
            frame_last = 1'b1;
`endif
          end
        end
      end
      default: begin
`ifdef MEDIAN_LINE_BUF_ZERO_PAD_EN
        emit = 1'b1;
        if (col_last && row_cnt == FLUSH_LAST) begin
          state_nxt  = IDLE;
          frame_last = 1'b1;
        end
`else
        state_nxt = IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (shift_en) begin
        if (col_last) begin
          col_cnt <= '0;
          row_cnt <= frame_last ? '0 : row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end
    end
  end

  // Taps hold between beats; done_o/frame_done_o are single-cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < WIN; k++) tap_q[k] <= '0;
      done_o       <= 1'b0;
      frame_done_o <= 1'b0;
    end else begin
      done_o       <= emit;
      frame_done_o <= frame_last;
      if (emit) begin
        for (int k = 0; k < WIN; k++) tap_q[k] <= tap[k];
      end
    end
  end

  assign d0_o = tap_q[0];
  assign d1_o = tap_q[1];
  assign d2_o = tap_q[2];
  assign d3_o = tap_q[3];
  assign d4_o = tap_q[4];
  assign d5_o = tap_q[5];
  assign d6_o = tap_q[6];

endmodule

// File: tb/tb_median_line_buffer_7row.sv
module tb_median_line_buffer_7row;
  import median_pkg::*;

  localparam int ROWS = 9;
  localparam int COLS = 9;
  localparam int W    = 57;   // {frame_done, d0..d6}

`ifdef MEDIAN_LINE_BUF_ZERO_PAD_EN
  localparam int CTR_FIRST = 0;
  localparam int CTR_LAST  = ROWS - 1;
  localparam int THR       = 3;
  localparam int EXP_BEATS = 81;
  localparam logic [55:0] FIRST_TAPS = {8'd0, 8'd0, 8'd0, 8'd0, 8'd9, 8'd18, 8'd27};
  localparam logic [55:0] LAST_TAPS  = {8'd53, 8'd62, 8'd71, 8'd80, 8'd0, 8'd0, 8'd0};
`else
  localparam int CTR_FIRST = 3;
  localparam int CTR_LAST  = ROWS - 4;
  localparam int THR       = 6;
  localparam int EXP_BEATS = 27;
  localparam logic [55:0] FIRST_TAPS = {8'd0, 8'd9, 8'd18, 8'd27, 8'd36, 8'd45, 8'd54};
  localparam logic [55:0] LAST_TAPS  = {8'd26, 8'd35, 8'd44, 8'd53, 8'd62, 8'd71, 8'd80};
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pixel_t d_i;
  logic   done_i;
  logic   ready_o;
  pixel_t d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o;
  logic   done_o, frame_done_o;
  state_t state_o;

  median_line_buffer_7row #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_i          (d_i),
    .done_i       (done_i),
    .ready_o      (ready_o),
    .d0_o         (d0_o),
    .d1_o         (d1_o),
    .d2_o         (d2_o),
    .d3_o         (d3_o),
    .d4_o         (d4_o),
    .d5_o         (d5_o),
    .d6_o         (d6_o),
    .done_o       (done_o),
    .frame_done_o (frame_done_o),
    .state_o      (state_o)
  );

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_w;
  logic [W-1:0] last_word = '0;
  int           beat_cnt = 0;
  int           fd_cnt = 0;
  int           ready_lo_cnt = 0;
  logic         prev_done = 1'b0;
  logic         prev_ready = 1'b1;
  bit           toggle_mode = 1'b0;
  logic [7:0]   frame_pix [ROWS][COLS];

  wire [W-1:0] dut_word = {frame_done_o, d0_o, d1_o, d2_o, d3_o, d4_o, d5_o, d6_o};

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst) begin
      if (done_o) begin
        beat_cnt++;
        if (frame_done_o) fd_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat got=%h required=none", dut_word);
        end else begin
          exp_w = exp_q.pop_front();
          if (dut_word !== exp_w) begin
            failures++;
            $display("FAIL beat got=%h required=%h", dut_word, exp_w);
          end
        end
        if (toggle_mode && prev_ready && ready_o) begin
          checks++;
          if (prev_done) begin
            failures++;
            $display("FAIL toggle_consecutive got=1 required=0");
          end
        end
        last_word = dut_word;
      end else begin
        checks++;
        if (dut_word[55:0] !== last_word[55:0] || frame_done_o !== 1'b0) begin
          failures++;
          $display("FAIL tap_hold got=%h required=%h", dut_word, {1'b0, last_word[55:0]});
        end
      end
      if (!ready_o) ready_lo_cnt++;
`ifndef MEDIAN_LINE_BUF_ZERO_PAD_EN
      checks++;
      if (ready_o !== 1'b1) begin
        failures++;
        $display("FAIL ready_high got=%b required=1", ready_o);
      end
`endif
      prev_done  = done_o;
      prev_ready = ready_o;
    end
  end

  // reference model: centre row ctr uses rows ctr-3..ctr+3, zero outside
  task automatic model_frame();
    logic [W-1:0] w;
    int row;
    for (int ctr = CTR_FIRST; ctr <= CTR_LAST; ctr++) begin
      for (int c = 0; c < COLS; c++) begin
        w = '0;
        w[56] = (ctr == CTR_LAST && c == COLS - 1);
        for (int k = 0; k < WIN; k++) begin
          row = ctr - HALF + k;
          if (row >= 0 && row < ROWS) w[8*(WIN-1-k) +: 8] = frame_pix[row][c];
        end
        exp_q.push_back(w);
      end
    end
  endtask

  task automatic fill_ramp(input int base);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        frame_pix[r][c] = 8'(r * COLS + c + base);
  endtask

  task automatic fill_random();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        frame_pix[r][c] = 8'($urandom);
  endtask

  // drivers
  task automatic send_pixel(input logic [7:0] p);
    int waited;
    waited = 0;
    @(negedge clk);
    done_i = 1'b1;
    // keep offering while the block refuses; the value must not be taken
    while (ready_o !== 1'b1 && waited < 200) begin
      d_i = 8'($urandom);
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout got=0 required=1");
    end
    d_i = p;
    @(posedge clk);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    done_i = 1'b0;
    d_i    = 8'($urandom);
    @(posedge clk);
  endtask

  task automatic end_input();
    @(negedge clk);
    done_i = 1'b0;
  endtask

  task automatic send_frame(input bit toggle, input int gap_pct, input bit chk_first);
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (toggle && (r != 0 || c != 0)) idle_cycle();
        else if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) idle_cycle();
        send_pixel(frame_pix[r][c]);
        if (chk_first && r == THR - 1 && c == COLS - 1) begin
          #1;
          checks++;
          if (done_o !== 1'b0) begin
            failures++;
            $display("FAIL pre_first_beat got=%b required=0", done_o);
          end
        end
        if (chk_first && r == THR && c == 0) begin
          #1;
          checks++;
          if (done_o !== 1'b1 || dut_word[55:0] !== FIRST_TAPS) begin
            failures++;
            $display("FAIL first_beat got=%b/%h required=1/%h", done_o, dut_word[55:0], FIRST_TAPS);
          end
        end
      end
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    repeat (5) @(negedge clk);
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b0; d_i = '0; done_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (dut_word !== '0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b required=0/0", dut_word, done_o);
    end
    checks++;
    if (ready_o !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b required=1", ready_o);
    end
    checks++;
    if (state_o !== IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d required=%0d", state_o, IDLE);
    end
    @(negedge clk);
    rst = 1'b1;
    last_word = '0;
  endtask

  task automatic test_ramp(input bit toggle);
    int b0, f0;
    fill_ramp(0);
    model_frame();
    b0 = beat_cnt; f0 = fd_cnt; ready_lo_cnt = 0;
    toggle_mode = toggle;
    send_frame(toggle, 0, 1'b1);
    end_input();
    wait_drain();
    toggle_mode = 1'b0;
    checks++;
    if (beat_cnt - b0 != EXP_BEATS) begin
      failures++;
      $display("FAIL beat_count got=%0d required=%0d", beat_cnt - b0, EXP_BEATS);
    end
    checks++;
    if (fd_cnt - f0 != 1) begin
      failures++;
      $display("FAIL frame_done_count got=%0d required=1", fd_cnt - f0);
    end
    checks++;
    if (last_word !== {1'b1, LAST_TAPS}) begin
      failures++;
      $display("FAIL last_beat got=%h required=%h", last_word, {1'b1, LAST_TAPS});
    end
`ifdef MEDIAN_LINE_BUF_ZERO_PAD_EN
    checks++;
    if (ready_lo_cnt != 3 * COLS) begin
      failures++;
      $display("FAIL flush_ready_low got=%0d required=%0d", ready_lo_cnt, 3 * COLS);
    end
`endif
  endtask

  task automatic test_reset_mid();
    fill_ramp(0);
    model_frame();
    for (int i = 0; i < 40; i++) send_pixel(frame_pix[i / COLS][i % COLS]);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dut_word !== '0 || done_o !== 1'b0) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h/%b required=0/0", dut_word, done_o);
    end
    checks++;
    if (ready_o !== 1'b1 || state_o !== IDLE) begin
      failures++;
      $display("FAIL async_reset_ctrl got=%b/%0d required=1/%0d", ready_o, state_o, IDLE);
    end
    exp_q.delete();
    last_word = '0;
    done_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    test_ramp(1'b0);
  endtask

  task automatic test_back_to_back();
    int f0, b0;
    f0 = fd_cnt; b0 = beat_cnt;
    fill_ramp(0);
    model_frame();
    send_frame(1'b0, 0, 1'b0);
    fill_ramp(100);
    model_frame();
    send_frame(1'b0, 0, 1'b0);
    end_input();
    wait_drain();
    checks++;
    if (fd_cnt - f0 != 2) begin
      failures++;
      $display("FAIL b2b_frame_done got=%0d required=2", fd_cnt - f0);
    end
    checks++;
    if (beat_cnt - b0 != 2 * EXP_BEATS) begin
      failures++;
      $display("FAIL b2b_beats got=%0d required=%0d", beat_cnt - b0, 2 * EXP_BEATS);
    end
  endtask

  task automatic test_random();
    int f0;
    f0 = fd_cnt;
    for (int f = 0; f < 3; f++) begin
      fill_random();
      model_frame();
      send_frame(1'b0, 30, 1'b0);
    end
    end_input();
    wait_drain();
    checks++;
    if (fd_cnt - f0 != 3) begin
      failures++;
      $display("FAIL random_frame_done got=%0d required=3", fd_cnt - f0);
    end
  endtask

  initial begin
    test_reset();
    test_ramp(1'b0);
    test_ramp(1'b1);
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
